// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bundle
// for the sequential restoring divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy,
    input  done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy,
    output done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit
// per clock, with start/done handshake.
module seq_divider #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic        clk,
  input logic        rst,
  seq_divider_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   a_nx;
  logic [WIDTH-1:0] q_sh;
  logic             last;

  // one restoring step: shift, trial subtract, restore on borrow
  always_comb begin
    a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    t    = a_sh - {1'b0, m_q};
    a_nx = t[WIDTH] ? a_sh : t;
    q_sh = {q_q[WIDTH-2:0], ~t[WIDTH]};
    last = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = (bus.divisor == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (last) state_d = S_DONE;
      S_DONE:  if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // decoded handshake outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (1'b1)
      (state_q == S_LOAD),
      (state_q == S_SHIFT): bus.busy = 1'b1;
      (state_q == S_DONE):  bus.done = 1'b1;
      default: ;
    endcase
  end

  // datapath next values; results only move on load or last step
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    unique case (state_q)
      S_LOAD: begin
        a_d   = '0;
        q_d   = bus.dividend;
        m_d   = bus.divisor;
        cnt_d = '0;
        if (bus.divisor == '0) begin
          quo_d = '1;
          rem_d = bus.dividend;
          dbz_d = 1'b1;
        end else begin
          dbz_d = 1'b0;
        end
      end
      S_SHIFT: begin
        a_d   = a_nx;
        q_d   = q_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          quo_d = q_sh;
          rem_d = a_nx[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider: unsigned WIDTH-bit dividend / WIDTH-bit divisor, producing quotient and remainder at one bit per clock. It is the inverse-operation companion to the shift-add sequential multiplier and sits on the same arithmetic path. It has integrated datapath and control, and uses the same start/done handshake as the multiplier.

Parameters:
WIDTH, 8, operand, quotient and remainder width (>= 2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in S_IDLE; must stay high until done is seen
dividend  input  WIDTH  unsigned dividend, sampled in S_LOAD
divisor  input  WIDTH  unsigned divisor, sampled in S_LOAD
quotient  output  WIDTH  registered result, valid while done=1
remainder  output  WIDTH  registered result, valid while done=1
busy  output  1  high in S_LOAD and S_SHIFT
done  output  1  high in S_DONE only
div_by_zero  output  1  high in S_DONE when the latched divisor was 0

Behaviour:
- Reset (rst=1 at clk edge): state=S_IDLE; A, Q, M, counter, quotient, remainder and div_by_zero all cleared to 0. busy=0 and done=0 (decoded). Reset wins over every other event, including mid-operation. The interrupted result is discarded.
- Registers: A (WIDTH+1 bits, partial remainder, signed on subtract), Q (WIDTH), M (WIDTH), cnt (CNT_W).
- FSM states: S_IDLE, S_LOAD, S_SHIFT, S_DONE.
  - S_IDLE -> S_LOAD when start=1. Otherwise stay.
  - S_LOAD: A<=0, Q<=dividend, M<=divisor, cnt<=0.
    - If divisor==0: go to S_DONE with quotient<={WIDTH{1}}, remainder<=dividend, div_by_zero<=1.
    - Else: go to S_SHIFT with div_by_zero<=0.
  - S_SHIFT, one iteration per cycle:
    - {A,Q} shifted left 1.
    - T = A_shifted - {1'b0,M}, at WIDTH+1 bits.
    - If T MSB=1 (negative): A keeps A_shifted (restore) and Q[0]=0.
    - Else: A<=T and Q[0]=1.
    - cnt<=cnt+1.
    - On the iteration where cnt==WIDTH-1: quotient<=final Q, remainder<=final A[WIDTH-1:0], then go to S_DONE.
  - S_DONE: done=1. Go to S_IDLE when start=0. If start is still 1, stay in S_DONE (no retrigger until start drops).
- Latency: start sampled high at edge N (S_IDLE). S_LOAD occupies cycle N+1. S_SHIFT occupies WIDTH cycles. done first high WIDTH+2 cycles after edge N. Divide-by-zero path: done high 2 cycles after edge N.
- quotient, remainder and div_by_zero hold their values after leaving S_DONE until the next S_LOAD completes. They change only in S_LOAD (div-by-zero path), on the final S_SHIFT cycle, or on reset.
- Operand changes during S_SHIFT have no effect (inputs are latched in S_LOAD).
- A start pulse that is high while busy is ignored.
- Invariants on non-zero divisor: dividend == quotient*divisor + remainder, and remainder < divisor.
- Boundary cases: dividend < divisor gives quotient=0, remainder=dividend. divisor=1 gives quotient=dividend, remainder=0. dividend=0 gives 0,0.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start held -> done rises exactly 10 cycles after start sampled; quotient=14, remainder=2, div_by_zero=0, busy high for 9 cycles.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Also dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=37, divisor=0 -> done 2 cycles after start, div_by_zero=1, quotient=8'hFF, remainder=37, no S_SHIFT cycles.
- Start 200/13, assert rst for 1 cycle at 4th S_SHIFT cycle -> next cycle state S_IDLE, busy=0, done=0, quotient=0, remainder=0. A fresh start of 200/13 then yields 15 r 5.
- Hold start high 5 cycles past done -> done stays high, no restart. Drop start -> S_IDLE next cycle with results held. Change operands during S_SHIFT -> result unchanged. Randomized 1000 operand pairs vs reference model, checking the invariants.
